risc16_exec_ctrl: RTL and testbench

Multi-cycle issue/execute/write-back controller for the 16-bit RISC datapath. It sits directly in front of the 8x16 register file. It accepts one instruction word at a time over a valid/ready handshake and drives the register file read addresses. It captures the two read operands, computes the result in an internal ALU, and writes the result back through the register file write port (WE/WR_addr/WR_data). It also maintains Z/N/C status flags.

---
 rtl/risc16_exec_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_risc16_exec_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_exec_ctrl.sv
// risc16_exec_ctrl
// Multi-cycle issue/execute/write-back controller for the 16-bit RISC datapath.
// It accepts one instruction at a time, reads two register-file operands,
// computes an ALU result, writes it back and keeps the {Z,N,C} flags.
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   instr, instr_valid   - instruction word and its valid strobe
//   instr_ready          - high only while idle
//   RA_addr/RB_addr      - register file read addresses
//   RA_data/RB_data      - register file combinational read data
//   WE/WR_addr/WR_data   - register file write port (WE high one cycle)
//   flags                - {Z,N,C}
//   retire, illegal      - one-cycle completion / undefined-opcode pulses
module risc16_exec_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] RA_addr,
  output logic [AW-1:0] RB_addr,
  input  logic [DW-1:0] RA_data,
  input  logic [DW-1:0] RB_data,
  output logic          WE,
  output logic [AW-1:0] WR_addr,
  output logic [DW-1:0] WR_data,
  output logic [2:0]    flags,
  output logic          retire,
  output logic          illegal
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;

  state_e        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] ra_addr_q, ra_addr_d, rb_addr_q, rb_addr_d;
  logic          we_q, we_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [2:0]    flags_q, flags_d;
  logic          retire_q, retire_d;
  logic          illegal_q, illegal_d;

  // ALU signals
  logic [3:0]      op;
  logic [DW:0]     sum;
  logic [2*DW-1:0] shl_w, shr_w;
  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic            writes, flag_upd, is_illegal;

  assign op = instr_q[15:12];

  always_comb begin
    sum        = '0;
    alu_res    = '0;
    alu_c      = 1'b0;
    writes     = 1'b1;
    flag_upd   = 1'b1;
    is_illegal = 1'b0;
    // Shifts done in a double-width field so the last bit shifted out lands
    // at a fixed position; a zero shift naturally yields a zero carry.
    shl_w = {{DW{1'b0}}, opa_q} << opb_q[3:0];
    shr_w = {opa_q, {DW{1'b0}}} >> opb_q[3:0];
    case (op)
      4'h1: begin
        sum     = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      4'h2: begin
        // Top bit of the widened difference is the unsigned borrow.
        sum     = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      4'h3: alu_res = opa_q & opb_q;
      4'h4: alu_res = opa_q | opb_q;
      4'h5: alu_res = opa_q ^ opb_q;
      4'h6: begin
        alu_res = shl_w[DW-1:0];
        alu_c   = shl_w[DW];
      end
      4'h7: begin
        alu_res = shr_w[2*DW-1:DW];
        alu_c   = shr_w[DW-1];
      end
      4'h8: begin
        sum     = {1'b0, opa_q} + {1'b0, {{(DW-6){instr_q[5]}}, instr_q[5:0]}};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      4'h9: begin
        alu_res  = {instr_q[7:0], {(DW-8){1'b0}}};
        flag_upd = 1'b0;
      end
      4'hA: begin
        alu_res  = opa_q;
        flag_upd = 1'b0;
      end
      4'h0: begin
        writes   = 1'b0;
        flag_upd = 1'b0;
      end
      default: begin
        writes     = 1'b0;
        flag_upd   = 1'b0;
        is_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    ready_d   = ready_q;
    ra_addr_d = ra_addr_q;
    rb_addr_d = rb_addr_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    flags_d   = flags_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (instr_valid && ready_q) begin
          instr_d   = instr;
          ra_addr_d = instr[8:6];
          rb_addr_d = instr[5:3];
          ready_d   = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = RA_data;
        opb_d   = RB_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (flag_upd) flags_d = {(alu_res == '0), alu_res[DW-1], alu_c};
        if (writes) begin
          we_d      = 1'b1;
          wr_addr_d = instr_q[11:9];
          wr_data_d = alu_res;
          state_d   = S_WB;
        end else begin
          retire_d  = 1'b1;
          illegal_d = is_illegal;
          ready_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WB: begin
        retire_d = 1'b1;
        ready_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      ready_q   <= 1'b1;
      ra_addr_q <= '0;
      rb_addr_q <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      flags_q   <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      ready_q   <= ready_d;
      ra_addr_q <= ra_addr_d;
      rb_addr_q <= rb_addr_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      flags_q   <= flags_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign RA_addr     = ra_addr_q;
  assign RB_addr     = rb_addr_q;
  assign WE          = we_q;
  assign WR_addr     = wr_addr_q;
  assign WR_data     = wr_data_q;
  assign flags       = flags_q;
  assign retire      = retire_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_risc16_exec_ctrl.sv
// Directed testbench for risc16_exec_ctrl with a behavioural 8x16 register file.
module tb_risc16_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  RA_addr, RB_addr, WR_addr;
  logic [15:0] RA_data, RB_data, WR_data;
  logic        WE;
  logic [2:0]  flags;
  logic        retire, illegal;

  int errors = 0;
  int checks = 0;

  // Register file model: combinational read, write at rising edge.
  logic [15:0] rf [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign RA_data = rf[RA_addr];
  assign RB_data = rf[RB_addr];

  always @(posedge clk) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (WE) rf[WR_addr] <= WR_data;
  end

  always #5 clk = ~clk;

  risc16_exec_ctrl #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .RA_addr(RA_addr), .RB_addr(RB_addr),
    .RA_data(RA_data), .RB_data(RB_data), .WE(WE), .WR_addr(WR_addr),
    .WR_data(WR_data), .flags(flags), .retire(retire), .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  // Issue one instruction from idle and follow it to completion, checking
  // the control pulses cycle by cycle.
  task automatic run_op(input logic [15:0] ins, input logic exp_wr,
                        input logic [15:0] exp_data, input logic [2:0] exp_flags,
                        input logic exp_ill, input string name);
    logic [3:0] exp_ctl, got;
    int n;
    n = exp_wr ? 4 : 3;
    instr = ins; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = ~ins;
    for (int c = 0; c < n; c++) begin
      got = {instr_ready, WE, retire, illegal};
      if (exp_wr) exp_ctl = (c == 2) ? 4'b0100 : (c == 3) ? 4'b1010 : 4'b0000;
      else        exp_ctl = (c == 2) ? {3'b101, exp_ill} : 4'b0000;
      checks++;
      if (got !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl c%0d {rdy,we,ret,ill}: got %b expected %b", name, c, got, exp_ctl);
      end
      if (c == 0) begin
        checks++;
        if ({RA_addr, RB_addr} !== {ins[8:6], ins[5:3]}) begin
          errors++;
          $display("FAIL %s raddr: got %0d,%0d expected %0d,%0d", name, RA_addr, RB_addr, ins[8:6], ins[5:3]);
        end
      end
      if (c == 2 && exp_wr) begin
        checks++;
        if (WR_addr !== ins[11:9] || WR_data !== exp_data) begin
          errors++;
          $display("FAIL %s wb: got r%0d=%h expected r%0d=%h", name, WR_addr, WR_data, ins[11:9], exp_data);
        end
      end
      if (c < n - 1) tick();
    end
    checks++;
    if (flags !== exp_flags) begin
      errors++;
      $display("FAIL %s flags: got %b expected %b", name, flags, exp_flags);
    end
    if (exp_wr) begin
      checks++;
      if (rf[ins[11:9]] !== exp_data) begin
        errors++;
        $display("FAIL %s rf: got %h expected %h", name, rf[ins[11:9]], exp_data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({instr_ready, WE, retire, illegal, flags} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset ctl: got %b expected 1000000", {instr_ready, WE, retire, illegal, flags});
    end
    checks++;
    if ({RA_addr, RB_addr, WR_addr, WR_data} !== 25'd0) begin
      errors++;
      $display("FAIL reset addr/data: got %h expected 0", {RA_addr, RB_addr, WR_addr, WR_data});
    end
  endtask

  task automatic test_add();
    preload(3'd1, 16'h0005); preload(3'd2, 16'h0003);
    run_op(16'h1650, 1'b1, 16'h0008, 3'b000, 1'b0, "add");
  endtask

  task automatic test_sub();
    preload(3'd1, 16'h0003); preload(3'd2, 16'h0005);
    run_op(16'h2850, 1'b1, 16'hFFFE, 3'b011, 1'b0, "sub_neg");
    run_op(16'h2A48, 1'b1, 16'h0000, 3'b100, 1'b0, "sub_zero");
  endtask

  task automatic test_logic_shift();
    preload(3'd1, 16'h8001); preload(3'd2, 16'h0001);
    run_op(16'h6650, 1'b1, 16'h0002, 3'b001, 1'b0, "shl");
    run_op(16'h7850, 1'b1, 16'h4000, 3'b001, 1'b0, "shr");
    run_op(16'h5A48, 1'b1, 16'h0000, 3'b100, 1'b0, "xor");
  endtask

  task automatic test_addi_lui();
    preload(3'd1, 16'hFFFF);
    run_op(16'h8C41, 1'b1, 16'h0000, 3'b101, 1'b0, "addi");
    run_op(16'h9EAB, 1'b1, 16'hAB00, 3'b101, 1'b0, "lui");
  endtask

  task automatic test_illegal_nop();
    run_op(16'hF000, 1'b0, 16'h0000, 3'b101, 1'b1, "illegal");
    run_op(16'h0000, 1'b0, 16'h0000, 3'b101, 1'b0, "nop");
  endtask

  task automatic test_back_to_back();
    int last, nhs, nwe;
    logic seen_ill;
    preload(3'd1, 16'h1234); preload(3'd2, 16'h0000);
    last = -1; nhs = 0; nwe = 0; seen_ill = 1'b0;
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (instr_ready) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4) begin
            errors++;
            $display("FAIL b2b spacing: got %0d expected 4", cyc - last);
          end
        end
        nhs++;
        last = cyc;
      end
      if (WE) begin
        nwe++;
        checks++;
        if (WR_addr !== 3'd2 || WR_data !== 16'h1234) begin
          errors++;
          $display("FAIL b2b wb: got r%0d=%h expected r2=1234", WR_addr, WR_data);
        end
      end
      if (illegal) seen_ill = 1'b1;
      // garbage while busy must never be captured
      instr = instr_ready ? 16'hA440 : 16'hF000;
      tick();
    end
    instr_valid = 1'b0;
    tick();
    checks++;
    if (nhs != 3 || nwe != 3 || seen_ill !== 1'b0) begin
      errors++;
      $display("FAIL b2b counts: got hs=%0d we=%0d ill=%b expected 3 3 0", nhs, nwe, seen_ill);
    end
    checks++;
    if (rf[2] !== 16'h1234 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b end: got r2=%h rdy=%b expected 1234 1", rf[2], instr_ready);
    end
  endtask

  task automatic test_reset_pending_write();
    preload(3'd1, 16'h0005); preload(3'd2, 16'h0003); preload(3'd3, 16'h7777);
    instr = 16'h1650; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    // in EXEC: the edge that would raise WE instead resets
    rst = 1'b1;
    tick();
    checks++;
    if ({instr_ready, WE, retire, illegal, flags} !== 7'b1000000) begin
      errors++;
      $display("FAIL rstwb ctl: got %b expected 1000000", {instr_ready, WE, retire, illegal, flags});
    end
    checks++;
    if ({RA_addr, RB_addr, WR_addr, WR_data} !== 25'd0) begin
      errors++;
      $display("FAIL rstwb addr/data: got %h expected 0", {RA_addr, RB_addr, WR_addr, WR_data});
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (rf[3] !== 16'h7777 || WE !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwb r3: got r3=%h we=%b rdy=%b expected 7777 0 1", rf[3], WE, instr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_addi_lui();
    test_illegal_nop();
    test_back_to_back();
    test_reset_pending_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
